// File: rtl/cnn_pkg.sv
// Shared defaults and FSM state encoding for the convolution layer memory loader.
package cnn_pkg;
  localparam int DATA_SZ   = 16;
  localparam int ADDR_SZ   = 16;
  localparam int BUF_WORDS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE,
    ST_RELEASE
  } loader_state_t;
endpackage

// File: rtl/conv_mem_loader_if.sv
// Single-port synchronous RAM bus shared by the loader's read and write channels.
interface conv_mem_loader_if #(
  parameter int ADDR_SZ = cnn_pkg::ADDR_SZ,
  parameter int DATA_SZ = cnn_pkg::DATA_SZ
);
  logic [ADDR_SZ-1:0] mem_addr;
  logic               mem_rd_en;
  logic               mem_wr_en;
  logic [DATA_SZ-1:0] mem_wdata;
  logic [DATA_SZ-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/conv_mem_loader_mem_port_arbiter.sv
// Puts either a write or a read on the RAM port (write wins) and tracks the one
// read in flight so its data can be steered into the window buffer a cycle later.
module mem_port_arbiter #(
  parameter int ADDR_SZ = cnn_pkg::ADDR_SZ,
  parameter int DATA_SZ = cnn_pkg::DATA_SZ,
  parameter int IDX_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_req,
  input  logic [ADDR_SZ-1:0] wr_addr,
  input  logic [DATA_SZ-1:0] wr_data,
  input  logic               rd_req,
  input  logic [ADDR_SZ-1:0] rd_addr,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               stall,
  output logic               cap_vld,
  output logic [IDX_W-1:0]   cap_idx,
  conv_mem_loader_if.master  mem
);
  logic             rd_go;
  logic             cap_vld_d, cap_vld_q;
  logic [IDX_W-1:0] cap_idx_d, cap_idx_q;

  always_comb begin
    mem.mem_addr  = '0;
    mem.mem_rd_en = 1'b0;
    mem.mem_wr_en = 1'b0;
    mem.mem_wdata = '0;
    rd_go         = rd_req & ~wr_req;
    stall         = rd_req & wr_req;
    if (wr_req) begin
      mem.mem_wr_en = 1'b1;
      mem.mem_addr  = wr_addr;
      mem.mem_wdata = wr_data;
    end else if (rd_req) begin
      mem.mem_rd_en = 1'b1;
      mem.mem_addr  = rd_addr;
    end
    cap_vld_d = rd_go;
    cap_idx_d = rd_go ? rd_idx : cap_idx_q;
  end

  // Stage boundary: issued read -> RAM data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= cap_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    cap_idx_q <= cap_idx_d;
  end

  assign cap_vld = cap_vld_q;
  assign cap_idx = cap_idx_q;
endmodule

// File: rtl/conv_mem_loader.sv
// Streams a loadSize x loadSize window from RAM into a flat buffer on request and
// forwards the layer's pixel writes onto the same RAM port.
module conv_mem_loader #(
  parameter int DATA_SZ   = cnn_pkg::DATA_SZ,
  parameter int ADDR_SZ   = cnn_pkg::ADDR_SZ,
  parameter int BUF_WORDS = cnn_pkg::BUF_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      loadEnable,
  input  logic [ADDR_SZ-1:0]        loadAddr,
  input  logic [DATA_SZ-1:0]        loadSize,
  output logic signed [DATA_SZ-1:0] loadOut [BUF_WORDS],
  output logic                      loadDone,
  output logic                      loadErr,
  input  logic                      writeEnable,
  input  logic [ADDR_SZ-1:0]        writeAddr,
  input  logic [DATA_SZ-1:0]        writeOut,
  output logic                      busy,
  conv_mem_loader_if.master         mem
);
  import cnn_pkg::*;

  localparam int IDX_W  = $clog2(BUF_WORDS + 1);
  localparam int BUF_AW = $clog2(BUF_WORDS);
  localparam int PROD_W = 2 * DATA_SZ;

  // Oversized requests are clipped to the buffer depth.
  function automatic logic [IDX_W-1:0] sat_total(input logic [PROD_W-1:0] p);
    if (p > PROD_W'(BUF_WORDS)) return IDX_W'(BUF_WORDS);
    return p[IDX_W-1:0];
  endfunction

  loader_state_t             state_d, state_q;
  logic [ADDR_SZ-1:0]        base_d, base_q;
  logic [IDX_W-1:0]          total_d, total_q;
  logic [IDX_W-1:0]          idx_d, idx_q;
  logic                      err_d, err_q;
  logic                      done_d, done_q;
  logic [PROD_W-1:0]         prod;
  logic                      over;
  logic                      rd_req, wr_req, stall;
  logic                      cap_vld;
  logic [BUF_AW-1:0]         cap_idx;
  logic [ADDR_SZ-1:0]        rd_addr;
  logic signed [DATA_SZ-1:0] buf_q [BUF_WORDS];

  assign prod    = PROD_W'(loadSize) * PROD_W'(loadSize);
  assign over    = prod > PROD_W'(BUF_WORDS);
  assign rd_addr = base_q + ADDR_SZ'(idx_q);
  // Holding reset masks writes so the RAM port idles at zero.
  assign wr_req  = writeEnable & reset;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    total_d = total_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rd_req  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (loadEnable) begin
          base_d  = loadAddr;
          total_d = sat_total(prod);
          idx_d   = '0;
          if (over) err_d = 1'b1;
          state_d = (prod == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        rd_req = 1'b1;
        if (!stall) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == total_q - IDX_W'(1)) state_d = ST_DRAIN;
        end
      end
      // Only one read is ever in flight, so its data lands at the end of this cycle.
      ST_DRAIN:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_RELEASE;
      ST_RELEASE: if (!loadEnable) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      total_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

  mem_port_arbiter #(
    .ADDR_SZ (ADDR_SZ),
    .DATA_SZ (DATA_SZ),
    .IDX_W   (BUF_AW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .wr_req  (wr_req),
    .wr_addr (writeAddr),
    .wr_data (writeOut),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_idx  (idx_q[BUF_AW-1:0]),
    .stall   (stall),
    .cap_vld (cap_vld),
    .cap_idx (cap_idx),
    .mem     (mem)
  );

  // Stage boundary: RAM read data -> window buffer
  always_ff @(posedge clk) begin
    if (cap_vld) buf_q[cap_idx] <= $signed(mem.mem_rdata);
  end

  assign loadOut  = buf_q;
  assign loadDone = done_q;
  assign loadErr  = err_q;
  assign busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_conv_mem_loader.sv
// Directed plus randomized bench for conv_mem_loader against a window/latency model.
module tb_conv_mem_loader;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int BW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, loadEnable, writeEnable;
  logic [AW-1:0]        loadAddr, writeAddr;
  logic [DW-1:0]        loadSize, writeOut;
  logic signed [DW-1:0] load_out [BW];
  logic                 loadDone, loadErr, busy;

  conv_mem_loader_if #(.ADDR_SZ(AW), .DATA_SZ(DW)) mem_if ();

  conv_mem_loader #(.DATA_SZ(DW), .ADDR_SZ(AW), .BUF_WORDS(BW)) dut (
    .clk         (clk),
    .reset       (reset),
    .loadEnable  (loadEnable),
    .loadAddr    (loadAddr),
    .loadSize    (loadSize),
    .loadOut     (load_out),
    .loadDone    (loadDone),
    .loadErr     (loadErr),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeOut    (writeOut),
    .busy        (busy),
    .mem         (mem_if)
  );

  // External RAM device
  logic [DW-1:0] ram [65536];
  logic          ram_init = 1'b0;
  logic [DW-1:0] ram_key  = '0;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < 65536; a++) ram[a] <= DW'(a) ^ ram_key;
    end else if (mem_if.mem_wr_en) begin
      ram[mem_if.mem_addr] <= mem_if.mem_wdata;
    end
    if (mem_if.mem_rd_en) mem_if.mem_rdata <= ram[mem_if.mem_addr];
  end

  // Reference model state
  logic [DW-1:0] model_mem [65536];
  logic [DW-1:0] exp_buf [BW];
  bit            exp_ok [BW];
  bit            exp_err = 1'b0;

  int nvec = 0, nerr = 0;
  int edge_cnt = 0, done_cnt = 0, done_edge = 0, rd_cnt = 0;
  logic [AW-1:0] rd_q [$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_if.mem_rd_en === 1'b1) begin
      rd_q.push_back(mem_if.mem_addr);
      rd_cnt++;
    end
    if (loadDone === 1'b1) begin
      done_cnt++;
      done_edge = edge_cnt;
    end
    if (mem_if.mem_rd_en === 1'b1 && mem_if.mem_wr_en === 1'b1)
      chk("rd_wr_exclusive", 32'd1, 32'd0);
  end

  task automatic mem_fill(input logic [DW-1:0] key);
    for (int a = 0; a < 65536; a++) model_mem[a] = DW'(a) ^ key;
    ram_key  = key;
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [AW-1:0] base, input logic [DW-1:0] size,
                          input int n_wr, input bit hold);
    logic [63:0]   sq;
    int            n, d0, r0, req, budget, bad, exp_edge;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] wq [$];
    sq = 64'(size) * 64'(size);
    n  = (sq > 64'(BW)) ? BW : int'(sq);
    if (sq > 64'(BW)) exp_err = 1'b1;
    d0 = done_cnt;
    r0 = rd_cnt;
    rd_q.delete();
    loadAddr   = base;
    loadSize   = size;
    loadEnable = 1'b1;
    @(posedge clk); #1;
    req = edge_cnt;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    if (!hold) loadEnable = 1'b0;
    if (n_wr > 0) begin
      @(posedge clk); #1;
      for (int k = 0; k < n_wr; k++) begin
        wa = base + 16'h8000 + AW'(4 * k) + AW'($urandom_range(0, 3));
        wd = DW'($urandom);
        writeEnable = 1'b1;
        writeAddr   = wa;
        writeOut    = wd;
        #2;
        chk({tag, "_wr_en"},   32'(mem_if.mem_wr_en), 32'd1);
        chk({tag, "_wr_addr"}, 32'(mem_if.mem_addr),  32'(wa));
        chk({tag, "_wr_data"}, 32'(mem_if.mem_wdata), 32'(wd));
        model_mem[wa] = wd;
        wq.push_back(wa);
        @(posedge clk); #1;
      end
      writeEnable = 1'b0;
    end
    budget = 3000;
    while (done_cnt == d0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    exp_edge = (n == 0) ? req + 1 : req + n + 2 + n_wr;
    chk({tag, "_done_latency"}, 32'(done_edge - req), 32'(exp_edge - req));
    repeat (hold ? 30 : 3) begin
      @(posedge clk); #1;
    end
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_rd_count"}, 32'(rd_cnt - r0), 32'(n));
    bad = 0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== AW'(base + AW'(i))) bad++;
    chk({tag, "_rd_addr_bad"}, 32'(bad), 32'd0);
    for (int i = 0; i < n; i++) begin
      exp_buf[i] = model_mem[AW'(base + AW'(i))];
      exp_ok[i]  = 1'b1;
    end
    bad = 0;
    for (int i = 0; i < BW; i++)
      if (exp_ok[i] && load_out[i] !== exp_buf[i]) bad++;
    chk({tag, "_buf_bad"}, 32'(bad), 32'd0);
    for (int k = 0; k < wq.size(); k++)
      chk({tag, "_ram_written"}, 32'(ram[wq[k]]), 32'(model_mem[wq[k]]));
    chk({tag, "_err"}, 32'(loadErr), 32'(exp_err));
    chk({tag, "_busy_end"}, 32'(busy), 32'(hold));
  endtask

  initial begin
    int d0;
    logic [AW-1:0] rb;
    logic [DW-1:0] rs;
    int nw;
    reset       = 1'b0;
    loadEnable  = 1'b0;
    loadAddr    = '0;
    loadSize    = '0;
    writeEnable = 1'b0;
    writeAddr   = '0;
    writeOut    = '0;
    mem_fill(16'h0000);
    @(posedge clk); #1;
    chk("rst_busy",  32'(busy),              32'd0);
    chk("rst_done",  32'(loadDone),          32'd0);
    chk("rst_err",   32'(loadErr),           32'd0);
    chk("rst_rd_en", 32'(mem_if.mem_rd_en),  32'd0);
    chk("rst_wr_en", 32'(mem_if.mem_wr_en),  32'd0);
    chk("rst_addr",  32'(mem_if.mem_addr),   32'd0);
    chk("rst_wdata", 32'(mem_if.mem_wdata),  32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_load("basic3",  16'h0100, 16'd3, 0, 1'b0);
    run_load("stall2",  16'h0100, 16'd3, 2, 1'b0);
    run_load("zero",    16'h0300, 16'd0, 0, 1'b0);
    run_load("big33",   16'h1000, 16'd33, 0, 1'b0);

    run_load("hold",    16'h0400, 16'd2, 0, 1'b1);
    loadEnable = 1'b0;
    @(posedge clk); #1;
    chk("hold_release_idle", 32'(busy), 32'd0);
    run_load("relaunch", 16'h0500, 16'd3, 0, 1'b0);

    run_load("wrap",    16'hFFFE, 16'd2, 0, 1'b0);

    // Reset in the middle of a 25-word load
    d0         = done_cnt;
    loadAddr   = 16'h0200;
    loadSize   = 16'd5;
    loadEnable = 1'b1;
    @(posedge clk); #1;
    loadEnable = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_busy",  32'(busy),             32'd0);
    chk("midrst_done",  32'(loadDone),         32'd0);
    chk("midrst_err",   32'(loadErr),          32'd0);
    chk("midrst_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
    chk("midrst_wr_en", 32'(mem_if.mem_wr_en), 32'd0);
    chk("midrst_addr",  32'(mem_if.mem_addr),  32'd0);
    exp_err = 1'b0;
    for (int i = 0; i < 25; i++) exp_ok[i] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_load("after_rst", 16'h0600, 16'd4, 0, 1'b0);

    mem_fill(DW'($urandom));
    for (int t = 0; t < 10; t++) begin
      rb = AW'($urandom);
      rs = DW'($urandom_range(0, 12));
      nw = (rs >= 2) ? int'($urandom_range(0, 3)) : 0;
      run_load($sformatf("rand%0d", t), rb, rs, nw, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/conv_mem_loader.md
# conv_mem_loader

Memory-side responder for the convolution layer's load and write channels. It services a load request (start address and square side `loadSize`) by streaming `loadSize*loadSize` words from a single-port synchronous RAM into a flat window buffer, then pulses `loadDone`. It also forwards output-pixel writes from the layer into the same RAM, arbitrating the single RAM port between the two channels. It sits between `convolution_layer` and the shared feature/filter memory.

## Interface
- `DATA_SZ`, 16, word width
- `ADDR_SZ`, 16, RAM address width
- `BUF_WORDS`, 1024, window buffer depth (words)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `loadEnable`  in  1  load request (level)
- `loadAddr`  in  ADDR_SZ  first word address
- `loadSize`  in  DATA_SZ  window side; word count = `loadSize*loadSize`
- `loadOut`  out  DATA_SZ x BUF_WORDS  signed window buffer, index 0 = word at `loadAddr`
- `loadDone`  out  1  one-cycle completion pulse
- `loadErr`  out  1  sticky: a request exceeded `BUF_WORDS`
- `writeEnable`  in  1  write strobe, one word per high cycle
- `writeAddr`  in  ADDR_SZ  write address
- `writeOut`  in  DATA_SZ  write data
- `mem_addr`  out  ADDR_SZ  RAM address
- `mem_rd_en`  out  1  RAM read; data valid on `mem_rdata` one cycle later
- `mem_wr_en`  out  1  RAM write
- `mem_wdata`  out  DATA_SZ  RAM write data
- `mem_rdata`  in  DATA_SZ  RAM read data
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM: IDLE -> READ -> DRAIN -> DONE -> RELEASE -> IDLE.
- IDLE: on `loadEnable`=1, latch `loadAddr`, compute `total = loadSize*loadSize` at 2*DATA_SZ bits; clamp to `BUF_WORDS` and set `loadErr` if larger. `total`=0 goes straight to DONE (no reads).
- READ: each non-stalled cycle drive `mem_rd_en`=1, `mem_addr = base + idx` (mod 2^ADDR_SZ), idx++. After issuing idx = total-1, go to DRAIN.
- A 1-bit in-flight flag plus captured index follow each issued read; on the next cycle `mem_rdata` is stored to `loadOut[captured idx]`.
- DRAIN: wait for the last read data to land.
- DONE: `loadDone`=1 for exactly one cycle.
- RELEASE: wait for `loadEnable`=0, then return to IDLE. This prevents a level request from re-triggering.
- Writes: when `writeEnable`=1, drive `mem_wr_en`=1, `mem_addr=writeAddr`, `mem_wdata=writeOut` in the same cycle, in every state. A write has priority; a READ issue in that cycle is stalled. In-flight data still captures.
- `loadOut` entries at idx >= total keep their previous values. The buffer is stable from `loadDone` until the next accepted request.
- `loadErr` clears only on reset.

## Timing
- Reset (async assert, sync-released use): state IDLE. `loadDone`, `loadErr`, `busy`, `mem_rd_en`, `mem_wr_en` = 0. `mem_addr`, `mem_wdata` = 0. `loadOut` is not reset.
- Load latency, no write stalls: with the request sampled at edge 0, reads issue on edges 1..N, data lands on edges 2..N+1, and `loadDone` is high for the cycle after edge N+2. Each stall cycle adds 1.
- `total`=0: `loadDone` is high for the cycle after edge 1.
- `loadEnable` held high through DONE: one `loadDone` only. No new request is accepted until low for at least 1 cycle.
- `loadEnable` deasserted mid-READ: the load completes anyway.
- Simultaneous write and read issue: the write goes out, the read slips one cycle. `mem_rd_en` and `mem_wr_en` are never high together.
- Address wrap: base 0xFFFE with 4 words reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset asserted mid-load: immediate IDLE, no `loadDone`, partial buffer contents undefined.

## Structure
- Package `cnn_pkg`: `DATA_SZ`, `ADDR_SZ`, `BUF_WORDS` defaults, and the FSM state enum `loader_state_t`.
- One sub-module, `mem_port_arbiter`: a combinational-plus-registered mux of write vs. read onto `mem_*`, with a stall output.

## Test plan
- Reset, then `loadSize`=3 at 0x0100 with RAM[a]=a -> reads 0x0100..0x0108. `loadOut[0..8]` = 0x0100..0x0108, `loadDone` 11 cycles after the sampling edge, one pulse.
- Same load with `writeEnable` high for 2 cycles mid-READ -> both writes land in RAM, `loadDone` delayed by exactly 2, data still correct.
- `loadSize`=0 -> no `mem_rd_en`, `loadDone` next cycle. `loadSize`=33 (1089 words) -> 1024 words loaded, `loadErr`=1.
- `loadEnable` held high for 30 cycles after `loadDone` -> no second transfer. Drop for 1 cycle and raise -> a new load starts.
- Base 0xFFFE, size 2 -> addresses wrap to 0x0000/0x0001, `loadOut[2..3]` = RAM[0..1].
- `reset` low mid-READ -> all outputs 0 asynchronously, `busy`=0. A subsequent load completes normally.
